div_unit: RTL

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- iterative 32-bit restoring divider (DIV / DIVU).
//
// Takes a level request from EX. One quotient bit is produced per cycle, so a
// nonzero divisor takes 32 iterations plus one sign-correction cycle. A zero
// divisor short-circuits to a zero result. The result is held in END until EX
// drops start_i.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   signed_i    1 = signed divide (DIV), 0 = unsigned (DIVU)
//   dividend_i  32-bit dividend, sampled only when a division is accepted
//   divisor_i   32-bit divisor, sampled only when a division is accepted
//   start_i     level request, held high until ready_o is seen
//   cancel_i    abort the current division (only with DIV_CANCEL_EN)
//   result_o    {remainder, quotient}, registered
//   ready_o     result_o valid, registered
//
// Build option:
//   DIV_CANCEL_EN  adds cancel_i. Without it, a division can only be stopped
//                  by rst.
//
// States:
//   IDLE    | waiting for start_i; outputs zero
//   DIVZERO | divisor was zero; zero result goes out on the next edge
//   ON      | shift-subtract iterations, then sign correction
//   END     | result valid; held until start_i drops
// -----------------------------------------------------------------------------
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        start_i,
`ifdef DIV_CANCEL_EN
  input  logic        cancel_i,
`endif
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

  state_t      state_q, state_d;
  logic        signed_q, signed_d;
  logic        neg_q, neg_d;       // operand signs differ
  logic        dsgn_q, dsgn_d;     // dividend was negative
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic        cancel;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

`ifdef DIV_CANCEL_EN
  assign cancel = cancel_i;
`else
  assign cancel = 1'b0;
`endif

  // The shifted remainder needs 33 bits: with a divisor >= 2^31 the partial
  // remainder can exceed 32 bits before the trial subtract.
  assign rem_sh = {rem_q, quo_q[31]};
  assign diff   = rem_sh - {1'b0, dvs_q};

  assign q_fix = (signed_q && neg_q)  ? (32'd0 - quo_q) : quo_q;
  assign r_fix = (signed_q && dsgn_q) ? (32'd0 - rem_q) : rem_q;

  always_comb begin
    state_d  = state_q;
    signed_d = signed_q;
    neg_d    = neg_q;
    dsgn_d   = dsgn_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ready_d  = ready_q;

    case (state_q)
      IDLE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (start_i) begin
          if (divisor_i == 32'd0) begin
            state_d = DIVZERO;
          end else begin
            state_d  = ON;
            signed_d = signed_i;
            neg_d    = dividend_i[31] ^ divisor_i[31];
            dsgn_d   = dividend_i[31];
            rem_d    = '0;
            quo_d    = (signed_i && dividend_i[31]) ? (32'd0 - dividend_i) : dividend_i;
            dvs_d    = (signed_i && divisor_i[31])  ? (32'd0 - divisor_i)  : divisor_i;
            cnt_d    = '0;
          end
        end
      end

      DIVZERO: begin
        if (cancel) begin
          state_d  = IDLE;
          ready_d  = 1'b0;
          result_d = '0;
        end else begin
          state_d  = END;
          ready_d  = 1'b1;
          result_d = '0;
        end
      end

      ON: begin
        if (cancel) begin
          state_d  = IDLE;
          ready_d  = 1'b0;
          result_d = '0;
        end else if (cnt_q == 6'd32) begin
          state_d  = END;
          ready_d  = 1'b1;
          result_d = {r_fix, q_fix};
        end else begin
          // No borrow: keep the difference and set the quotient bit.
          if (!diff[32]) begin
            rem_d = diff[31:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = rem_sh[31:0];
            quo_d = {quo_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 6'd1;
        end
      end

      END: begin
        if (cancel || !start_i) begin
          state_d  = IDLE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end

      default: begin
        state_d  = IDLE;
        ready_d  = 1'b0;
        result_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      signed_q <= 1'b0;
      neg_q    <= 1'b0;
      dsgn_q   <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      signed_q <= signed_d;
      neg_q    <= neg_d;
      dsgn_q   <= dsgn_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule
